// File: rtl/five_line_checker.sv
// Five-in-a-row detector: walks the four line directions through a freshly placed stone.
// Optional build macro EXACT_FIVE_EN: only an exact run of WIN_LEN wins (overlines rejected).
module five_line_checker #(
  parameter int unsigned BOARD_DIM = 16,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned WIN_LEN   = 5
) (
  input  logic                               Clck,
  input  logic                               Reset,
  input  logic                               start,
  input  logic [2*BOARD_DIM*BOARD_DIM-1:0]   board,
  input  logic [COORD_W-1:0]                 loc_x,
  input  logic [COORD_W-1:0]                 loc_y,
  output logic                               busy,
  output logic                               done,
  output logic                               win,
  output logic [1:0]                         winner,
  output logic [1:0]                         win_dir,
  output logic [3:0]                         run_len
);

  localparam int unsigned BOARD_W = 2 * BOARD_DIM * BOARD_DIM;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned K_W     = 3;
  localparam int unsigned POS_W   = COORD_W + 2;
  localparam int unsigned IDX_W   = 2 * COORD_W + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ORIGIN   = 3'd1;
  localparam logic [2:0] S_WALK_POS = 3'd2;
  localparam logic [2:0] S_WALK_NEG = 3'd3;
  localparam logic [2:0] S_FIN      = 3'd4;

  localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(BOARD_DIM - 1);
  localparam logic [CNT_W-1:0]        CNT_WIN = CNT_W'(WIN_LEN);
  localparam logic [K_W-1:0]          K_LAST  = K_W'(WIN_LEN);

  logic [2:0]           state_q, state_d;
  logic [BOARD_W-1:0]   snap_q, snap_d;
  logic [COORD_W-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [1:0]           dir_q, dir_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [1:0]           colour_q, colour_d;
  logic                 busy_d, done_d, win_d;
  logic [1:0]           winner_d, win_dir_d;
  logic [3:0]           run_len_d;

  logic signed [POS_W-1:0] base_dx, base_dy, sx, sy, nx, ny;
  logic [IDX_W-1:0]        org_idx, nbr_idx;
  logic [1:0]              org_cell, nbr_cell;
  logic                    off_board, hit, side_end, qualifies;
  logic [CNT_W-1:0]        cnt_inc, cnt_side;

  // Neighbour address: one signed step from the last matching cell, never wrapping.
  always_comb begin
    base_dx = POS_W'(1);
    base_dy = '0;
    case (dir_q)
      2'd0: begin base_dx = POS_W'(1);  base_dy = '0;         end
      2'd1: begin base_dx = '0;         base_dy = POS_W'(1);  end
      2'd2: begin base_dx = POS_W'(1);  base_dy = POS_W'(1);  end
      default: begin base_dx = POS_W'(1); base_dy = -POS_W'(1); end
    endcase
    sx = (state_q == S_WALK_NEG) ? -base_dx : base_dx;
    sy = (state_q == S_WALK_NEG) ? -base_dy : base_dy;
    nx = $signed({2'b00, cx_q}) + sx;
    ny = $signed({2'b00, cy_q}) + sy;
    off_board = nx[POS_W-1] || ny[POS_W-1] || (nx > POS_MAX) || (ny > POS_MAX);
    nbr_idx  = {ny[COORD_W-1:0], nx[COORD_W-1:0], 1'b0};
    org_idx  = {oy_q, ox_q, 1'b0};
    nbr_cell = snap_q[nbr_idx +: 2];
    org_cell = snap_q[org_idx +: 2];
    hit      = !off_board && (nbr_cell == colour_q);
    cnt_inc  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
    cnt_side = hit ? cnt_inc : count_q;
    side_end = !hit || (k_q == K_LAST);
`ifdef EXACT_FIVE_EN
    qualifies = (cnt_side == CNT_WIN);
`else
    qualifies = (cnt_side >= CNT_WIN);
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    k_d       = k_q;
    dir_d     = dir_q;
    count_d   = count_q;
    colour_d  = colour_q;
    busy_d    = busy;
    done_d    = 1'b0;
    win_d     = win;
    winner_d  = winner;
    win_dir_d = win_dir;
    run_len_d = run_len;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d    = board;
          ox_d      = loc_x;
          oy_d      = loc_y;
          win_d     = 1'b0;
          winner_d  = 2'b00;
          win_dir_d = 2'b00;
          run_len_d = '0;
          busy_d    = 1'b1;
          state_d   = S_ORIGIN;
        end
      end
      S_ORIGIN: begin
        colour_d = org_cell;
        if (org_cell == 2'b00 || org_cell == 2'b11) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          count_d = CNT_W'(1);
          dir_d   = 2'd0;
          k_d     = K_W'(1);
          cx_d    = ox_q;
          cy_d    = oy_q;
          state_d = S_WALK_POS;
        end
      end
      S_WALK_POS: begin
        count_d = cnt_side;
        if (side_end) begin
          k_d     = K_W'(1);
          cx_d    = ox_q;
          cy_d    = oy_q;
          state_d = S_WALK_NEG;
        end else begin
          k_d  = k_q + K_W'(1);
          cx_d = nx[COORD_W-1:0];
          cy_d = ny[COORD_W-1:0];
        end
      end
      S_WALK_NEG: begin
        count_d = cnt_side;
        if (!side_end) begin
          k_d  = k_q + K_W'(1);
          cx_d = nx[COORD_W-1:0];
          cy_d = ny[COORD_W-1:0];
        end else begin
          if (cnt_side > run_len) run_len_d = cnt_side;
          if (qualifies) begin
            win_d     = 1'b1;
            winner_d  = colour_q;
            win_dir_d = dir_q;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_FIN;
          end else if (dir_q == 2'd3) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            dir_d   = dir_q + 2'd1;
            count_d = CNT_W'(1);
            k_d     = K_W'(1);
            cx_d    = ox_q;
            cy_d    = oy_q;
            state_d = S_WALK_POS;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      snap_q   <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      k_q      <= '0;
      dir_q    <= '0;
      count_q  <= '0;
      colour_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      win      <= 1'b0;
      winner   <= 2'b00;
      win_dir  <= 2'b00;
      run_len  <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      k_q      <= k_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      colour_q <= colour_d;
      busy     <= busy_d;
      done     <= done_d;
      win      <= win_d;
      winner   <= winner_d;
      win_dir  <= win_dir_d;
      run_len  <= run_len_d;
    end
  end

endmodule
